// File: rtl/scale_pkg.sv
// rtl/scale_pkg.sv - shared state encoding, widths and helpers for the scale weight path
package scale_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DIVIDE,
    DONE
  } state_e;

  localparam int GRAMS_PER_KG = 1000;
  localparam int GRAM_W       = 12;
  localparam int FRAC_W       = 10;
  localparam int NET_W        = 13;

  function automatic logic [GRAM_W-1:0] abs_diff(input logic [GRAM_W-1:0] a,
                                                 input logic [GRAM_W-1:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/kg_divider.sv
// rtl/kg_divider.sv - bit-serial restoring divide by GRAMS_PER_KG, one quotient bit per cycle, MSB first
module kg_divider
  import scale_pkg::*;
(
  input  logic              clk,
  input  logic              rstN,
  input  logic              start,
  input  logic [GRAM_W-1:0] dividend,
  output logic              done,
  output logic [GRAM_W-1:0] quotient,
  output logic [FRAC_W-1:0] remainder
);

  localparam int TRIAL_W = FRAC_W + 1;
  localparam int CNT_W   = $clog2(GRAM_W + 1);
  localparam logic [TRIAL_W-1:0] DIVISOR = TRIAL_W'(GRAMS_PER_KG);

  // dvd_q shifts dividend bits out of the top and quotient bits in at the bottom
  logic [GRAM_W-1:0]  dvd_q, dvd_d;
  logic [FRAC_W-1:0]  rem_q, rem_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [TRIAL_W-1:0] trial;

  always_comb begin
    dvd_d = dvd_q;
    rem_d = rem_q;
    cnt_d = cnt_q;
    trial = {rem_q, dvd_q[GRAM_W-1]};
    if (start) begin
      dvd_d = dividend;
      rem_d = '0;
      cnt_d = CNT_W'(GRAM_W);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
      if (trial >= DIVISOR) begin
        rem_d = FRAC_W'(trial - DIVISOR);
        dvd_d = {dvd_q[GRAM_W-2:0], 1'b1};
      end else begin
        rem_d = trial[FRAC_W-1:0];
        dvd_d = {dvd_q[GRAM_W-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstN) begin
      dvd_q <= '0;
      rem_q <= '0;
      cnt_q <= '0;
    end else begin
      dvd_q <= dvd_d;
      rem_q <= rem_d;
      cnt_q <= cnt_d;
    end
  end

  // done flags the final step, so results are settled on the following cycle
  assign done      = (cnt_q == CNT_W'(1));
  assign quotient  = dvd_q;
  assign remainder = rem_q;

endmodule

// File: rtl/scale_controller.sv
// rtl/scale_controller.sv - tare/net/kg sequencing controller for the scale weight path
// SCALE_DEFAULT_TARE_EN: tare register resets to DEFAULT_TARE instead of 0
module scale_controller
  import scale_pkg::*;
#(
  parameter int STABLE_TOL   = 5,
  parameter int STABLE_COUNT = 4,
  parameter int DEFAULT_TARE = 40
) (
  input  logic              clk,
  input  logic              rstN,
  input  logic              sampleValid,
  input  logic [GRAM_W-1:0] weightInGrams,
  input  logic              tareReq,
  output logic              busy,
  output logic              resultValid,
  output logic [GRAM_W-1:0] weightInKilogramsInteger,
  output logic [FRAC_W-1:0] weightInKilogramsFraction,
  output logic              underload,
  output logic              stable,
  output logic              tareDone,
  output logic              overrun
);

  localparam int CNT_W = $clog2(STABLE_COUNT + 1);
`ifdef SCALE_DEFAULT_TARE_EN
  localparam logic [GRAM_W-1:0] TARE_RESET = GRAM_W'(DEFAULT_TARE);
`else
  localparam logic [GRAM_W-1:0] TARE_RESET = GRAM_W'(DEFAULT_TARE) & '0;
`endif

  state_e            state_q, state_d;
  logic [GRAM_W-1:0] tare_q, tare_d;
  logic              tare_pend_q, tare_pend_d;
  logic              tare_done_q, tare_done_d;
  logic              overrun_q, overrun_d;
  logic              ul_pend_q, ul_pend_d;
  logic [GRAM_W-1:0] net_q, net_d;
  logic [GRAM_W-1:0] prev_net_q, prev_net_d;
  logic [CNT_W-1:0]  stab_cnt_q, stab_cnt_d;
  logic [GRAM_W-1:0] kg_int_q, kg_int_d;
  logic [FRAC_W-1:0] kg_frac_q, kg_frac_d;
  logic              underload_q, underload_d;
  logic              result_valid_q, result_valid_d;

  logic [NET_W-1:0]  net_raw;
  logic [GRAM_W-1:0] net_clamp;
  logic [GRAM_W-1:0] net_diff;
  logic              div_start;
  logic              div_done;
  logic [GRAM_W-1:0] div_quot;
  logic [FRAC_W-1:0] div_rem;

  kg_divider u_kg_divider (
    .clk       (clk),
    .rstN      (rstN),
    .start     (div_start),
    .dividend  (net_clamp),
    .done      (div_done),
    .quotient  (div_quot),
    .remainder (div_rem)
  );

  always_comb begin
    state_d        = state_q;
    tare_d         = tare_q;
    tare_pend_d    = tare_pend_q | tareReq;
    tare_done_d    = 1'b0;
    overrun_d      = overrun_q;
    ul_pend_d      = ul_pend_q;
    net_d          = net_q;
    prev_net_d     = prev_net_q;
    stab_cnt_d     = stab_cnt_q;
    kg_int_d       = kg_int_q;
    kg_frac_d      = kg_frac_q;
    underload_d    = underload_q;
    result_valid_d = 1'b0;
    div_start      = 1'b0;

    // sign bit of the 13-bit difference marks sample < tare
    net_raw   = {1'b0, weightInGrams} - {1'b0, tare_q};
    net_clamp = net_raw[NET_W-1] ? '0 : net_raw[GRAM_W-1:0];
    net_diff  = abs_diff(net_q, prev_net_q);

    case (state_q)
      IDLE: begin
        if (sampleValid) begin
          if (tare_pend_q || tareReq) begin
            tare_d      = weightInGrams;
            tare_pend_d = 1'b0;
            tare_done_d = 1'b1;
            stab_cnt_d  = '0;
            overrun_d   = 1'b0;
          end else begin
            net_d     = net_clamp;
            ul_pend_d = net_raw[NET_W-1];
            div_start = 1'b1;
            state_d   = DIVIDE;
          end
        end
      end
      DIVIDE: begin
        if (div_done) state_d = DONE;
      end
      DONE: begin
        kg_int_d       = div_quot;
        kg_frac_d      = div_rem;
        underload_d    = ul_pend_q;
        result_valid_d = 1'b1;
        prev_net_d     = net_q;
        if (net_diff <= GRAM_W'(STABLE_TOL)) begin
          if (stab_cnt_q != CNT_W'(STABLE_COUNT)) stab_cnt_d = stab_cnt_q + 1'b1;
        end else begin
          stab_cnt_d = '0;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (sampleValid && (state_q != IDLE)) overrun_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rstN) begin
      state_q        <= IDLE;
      tare_q         <= TARE_RESET;
      tare_pend_q    <= 1'b0;
      tare_done_q    <= 1'b0;
      overrun_q      <= 1'b0;
      ul_pend_q      <= 1'b0;
      net_q          <= '0;
      prev_net_q     <= '0;
      stab_cnt_q     <= '0;
      kg_int_q       <= '0;
      kg_frac_q      <= '0;
      underload_q    <= 1'b0;
      result_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      tare_q         <= tare_d;
      tare_pend_q    <= tare_pend_d;
      tare_done_q    <= tare_done_d;
      overrun_q      <= overrun_d;
      ul_pend_q      <= ul_pend_d;
      net_q          <= net_d;
      prev_net_q     <= prev_net_d;
      stab_cnt_q     <= stab_cnt_d;
      kg_int_q       <= kg_int_d;
      kg_frac_q      <= kg_frac_d;
      underload_q    <= underload_d;
      result_valid_q <= result_valid_d;
    end
  end

  assign busy                      = (state_q != IDLE);
  assign resultValid               = result_valid_q;
  assign weightInKilogramsInteger  = kg_int_q;
  assign weightInKilogramsFraction = kg_frac_q;
  assign underload                 = underload_q;
  assign stable                    = (stab_cnt_q == CNT_W'(STABLE_COUNT));
  assign tareDone                  = tare_done_q;
  assign overrun                   = overrun_q;

endmodule

// File: tb/tb_scale_controller.sv
// tb/tb_scale_controller.sv - scoreboard bench for scale_controller against an arithmetic reference model
module tb_scale_controller;

  localparam int TOL   = 5;
  localparam int COUNT = 4;
`ifdef SCALE_DEFAULT_TARE_EN
  localparam int DEF_TARE = 40;
`else
  localparam int DEF_TARE = 0;
`endif

  logic        clk = 1'b0;
  logic        rstN = 1'b0;
  logic        sampleValid = 1'b0;
  logic [11:0] weightInGrams = '0;
  logic        tareReq = 1'b0;
  logic        busy, resultValid, underload, stable, tareDone, overrun;
  logic [11:0] weightInKilogramsInteger;
  logic [9:0]  weightInKilogramsFraction;

  scale_controller #(
    .STABLE_TOL   (TOL),
    .STABLE_COUNT (COUNT),
    .DEFAULT_TARE (40)
  ) dut (
    .clk                       (clk),
    .rstN                      (rstN),
    .sampleValid               (sampleValid),
    .weightInGrams             (weightInGrams),
    .tareReq                   (tareReq),
    .busy                      (busy),
    .resultValid               (resultValid),
    .weightInKilogramsInteger  (weightInKilogramsInteger),
    .weightInKilogramsFraction (weightInKilogramsFraction),
    .underload                 (underload),
    .stable                    (stable),
    .tareDone                  (tareDone),
    .overrun                   (overrun)
  );

  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  typedef struct {
    int kg;
    int frac;
    bit ul;
    bit st;
    int cyc;
  } exp_t;

  exp_t exp_q[$];
  int   tare_ev_q[$];
  exp_t mon_x;
  int   mon_t;

  int n_tests = 0;
  int n_fail  = 0;

  int tare_m;
  bit pend_m;
  int prev_m;
  bit hist[$];
  bit ovr_m;
  int acc_m;

  task automatic check(input string name, input int act, input int expv);
    n_tests++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cycle);
    end
  endtask

  function automatic bit model_busy(input int c);
    return (c >= acc_m) && (c <= acc_m + 12);
  endfunction

  function automatic bit model_stable();
    if (hist.size() < COUNT) return 1'b0;
    for (int i = hist.size() - COUNT; i < hist.size(); i++)
      if (!hist[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    tare_m = DEF_TARE;
    pend_m = 1'b0;
    prev_m = 0;
    hist.delete();
    ovr_m  = 1'b0;
    acc_m  = -100;
    exp_q.delete();
    tare_ev_q.delete();
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic issue(input int s, input bit treq);
    int   e;
    int   net;
    bit   ul;
    exp_t x;
    sampleValid   = 1'b1;
    weightInGrams = s[11:0];
    tareReq       = treq;
    @(posedge clk);
    #1;
    e = cycle;
    sampleValid = 1'b0;
    tareReq     = 1'b0;
    if (treq) pend_m = 1'b1;
    if (model_busy(e - 1)) begin
      ovr_m = 1'b1;
    end else if (pend_m) begin
      tare_m = s;
      pend_m = 1'b0;
      hist.delete();
      ovr_m = 1'b0;
      tare_ev_q.push_back(e);
    end else begin
      net = s - tare_m;
      ul  = (net < 0);
      if (ul) net = 0;
      hist.push_back(((net > prev_m) ? (net - prev_m) : (prev_m - net)) <= TOL);
      prev_m = net;
      x.kg   = net / 1000;
      x.frac = net % 1000;
      x.ul   = ul;
      x.st   = model_stable();
      x.cyc  = e + 13;
      exp_q.push_back(x);
      acc_m  = e;
    end
  endtask

  task automatic tare_pulse();
    tareReq = 1'b1;
    @(posedge clk);
    #1;
    tareReq = 1'b0;
    pend_m  = 1'b1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_kg_int"},  int'(weightInKilogramsInteger), 0);
    check({tag, "_kg_frac"}, int'(weightInKilogramsFraction), 0);
    check({tag, "_underload"}, int'(underload), 0);
    check({tag, "_stable"},  int'(stable), 0);
    check({tag, "_overrun"}, int'(overrun), 0);
    check({tag, "_busy"},    int'(busy), 0);
    check({tag, "_result_valid"}, int'(resultValid), 0);
    check({tag, "_tare_done"}, int'(tareDone), 0);
  endtask

  always @(negedge clk) begin
    if (rstN) begin
      if (exp_q.size() > 0 && exp_q[0].cyc < cycle) begin
        mon_x = exp_q.pop_front();
        check("missing_result", 0, 1);
      end
      if (resultValid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result_valid", 1, 0);
        end else begin
          mon_x = exp_q.pop_front();
          check("result_cycle", cycle, mon_x.cyc);
          check("kg_int", int'(weightInKilogramsInteger), mon_x.kg);
          check("kg_frac", int'(weightInKilogramsFraction), mon_x.frac);
          check("underload", int'(underload), int'(mon_x.ul));
          check("stable", int'(stable), int'(mon_x.st));
        end
      end
      if (tare_ev_q.size() > 0 && tare_ev_q[0] < cycle) begin
        mon_t = tare_ev_q.pop_front();
        check("missing_tare_done", 0, 1);
      end
      if (tareDone) begin
        if (tare_ev_q.size() == 0) begin
          check("unexpected_tare_done", 1, 0);
        end else begin
          mon_t = tare_ev_q.pop_front();
          check("tare_done_cycle", cycle, mon_t);
        end
      end
      check("busy", int'(busy), int'(model_busy(cycle)));
      check("overrun", int'(overrun), int'(ovr_m));
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cycle);
    $fatal(1);
  end

  initial begin
    int gap;
    int s;
    bit t;

    model_reset();
    cycles(3);
    rstN = 1'b1;
    check_all_zero("reset");

    issue(2345, 1'b0);
    cycles(13);

    issue(40, 1'b1);
    cycles(1);
    issue(1040, 1'b0);
    cycles(13);
    issue(30, 1'b0);
    cycles(13);

    issue(500, 1'b1);
    cycles(2);
    issue(1750, 1'b0);
    cycles(13);

    issue(1200, 1'b0);
    cycles(4);
    issue(3333, 1'b0);
    cycles(10);

    issue(3000, 1'b0);
    repeat (7) @(posedge clk);
    #1;
    rstN = 1'b0;
    @(posedge clk);
    #1;
    model_reset();
    cycles(1);
    rstN = 1'b1;
    check_all_zero("mid_conv_reset");
    cycles(20);

    issue(0, 1'b1);
    cycles(1);
    issue(1000, 1'b0);
    cycles(13);
    issue(1003, 1'b0);
    cycles(13);
    issue(998, 1'b0);
    cycles(13);
    issue(1001, 1'b0);
    cycles(13);
    issue(1002, 1'b0);
    cycles(13);
    issue(1100, 1'b0);
    cycles(14);

    for (int i = 0; i < 60; i++) begin
      t   = ($urandom_range(0, 5) == 0);
      s   = t ? int'($urandom_range(0, 600)) : int'($urandom_range(0, 4095));
      if ($urandom_range(0, 2) == 0) s = prev_m + tare_m + int'($urandom_range(0, 12)) - 6;
      if (s < 0) s = 0;
      if (s > 4095) s = 4095;
      gap = $urandom_range(10, 15);
      issue(s, t);
      if ($urandom_range(0, 4) == 0) begin
        cycles(2);
        tare_pulse();
        cycles(gap - 3);
      end else begin
        cycles(gap);
      end
    end

    cycles(20);
    check("leftover_results", exp_q.size(), 0);
    check("leftover_tare_events", tare_ev_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/scale_controller.md
# scale_controller

Sequencing controller for the scale's weight path. It accepts raw gram samples, captures and applies the tare, and clamps the net weight at zero. It runs a bit-serial divide-by-1000 to produce kilogram integer and fraction outputs, and flags result stability. It sits between the load-cell sample source and the display/formatting logic, replacing the one-shot combinational grams-to-kilograms conversion with a registered, handshaked one.

## Interface
Parameters:
- `STABLE_TOL`, default 5: maximum absolute net-gram difference between consecutive results that still counts as stable.
- `STABLE_COUNT`, default 4: number of consecutive in-tolerance results required to assert `stable`.
- `DEFAULT_TARE`, default 40: tare value loaded at reset when `SCALE_DEFAULT_TARE_EN` is defined.

Ports (reset is synchronous, active-low, on `clk`):
- `clk` input, 1 bit: single clock; all logic is on the rising edge.
- `rstN` input, 1 bit: synchronous, active-low reset.
- `sampleValid` input, 1 bit: `weightInGrams` is valid this cycle.
- `weightInGrams` input, 12 bits: raw sample, unsigned grams.
- `tareReq` input, 1 bit: one-cycle pulse requesting a tare.
- `busy` output, 1 bit: a conversion is in flight, and samples are dropped.
- `resultValid` output, 1 bit: one-cycle pulse; the result outputs were updated this cycle.
- `weightInKilogramsInteger` output, 12 bits: net grams / 1000.
- `weightInKilogramsFraction` output, 10 bits: net grams % 1000.
- `underload` output, 1 bit: the last result had sample < tare, and net was clamped to 0.
- `stable` output, 1 bit: the stability criterion is met.
- `tareDone` output, 1 bit: one-cycle pulse; the tare register was updated.
- `overrun` output, 1 bit: sticky; a sample arrived while `busy`.

## Operation
- States: `IDLE`, `DIVIDE`, `DONE`.
- **`IDLE`, tare path.** On `sampleValid`, if a tare is pending (or `tareReq` is asserted in the same cycle):
  - the sample loads the tare register;
  - pending is cleared and `tareDone` is pulsed;
  - the stability counter and `overrun` are cleared;
  - no result is produced; state stays `IDLE`.
- **`IDLE`, measurement path.** On `sampleValid` with no tare pending:
  - net = sample − tare, computed 13-bit signed;
  - if net < 0, net = 0 and the underload flag is latched;
  - the divider is loaded with net; go to `DIVIDE`.
- **`DIVIDE`.** 12 restoring-division steps by the constant 1000, one quotient bit per cycle, MSB first. The remainder is 10-bit.
- **`DONE`.**
  - Register the quotient into `weightInKilogramsInteger` and the remainder into `weightInKilogramsFraction`; update `underload`.
  - Pulse `resultValid`; return to `IDLE`.
- **Stability** (evaluated in `DONE`):
  - If |net − previous net| ≤ `STABLE_TOL`, the counter increments, saturating at `STABLE_COUNT`; otherwise it resets to 0.
  - `stable` = (counter == `STABLE_COUNT`).
  - Previous net is updated every result.
- **`tareReq` at any time**, including while `busy`, sets tare-pending. Pending is consumed only by the next sample accepted in `IDLE`.
- **`sampleValid` outside `IDLE`**: the sample is ignored and `overrun` is set. Only a tare capture clears `overrun`.
- **Arithmetic:**
  - Maximum integer result is 4; the upper bits of the 12-bit integer output are zero.
  - Fraction is always 0..999.

## Timing
- A sample is accepted at edge E0. Edges E1–E12 are the division steps. At E13 the outputs update and `resultValid` = 1 for exactly one cycle.
- `busy` is high after E0 through E13, i.e. whenever the state is not `IDLE`. A sample at E14 is accepted.
- `tareDone` goes high for one cycle after the accepting edge.
- Reset values: all outputs 0; tare register as set by the configuration (see below); stability counter 0; tare-pending 0; state `IDLE`.
- Reset asserted mid-conversion abandons the conversion with no `resultValid`. The previous outputs are reset to 0.

## Configuration
- `SCALE_DEFAULT_TARE_EN` defined: the tare register resets to `DEFAULT_TARE` (40 g container allowance).
- Macro undefined: the tare register resets to 0, the `DEFAULT_TARE` parameter is unused, and net equals the raw sample until the first tare capture.

## Structure
- Shared package `scale_pkg` contains:
  - the state enum (`IDLE`/`DIVIDE`/`DONE`);
  - the constant `GRAMS_PER_KG` = 1000;
  - the widths `GRAM_W` = 12, `FRAC_W` = 10, `NET_W` = 13.
- Sub-module `kg_divider`:
  - a bit-serial restoring divider by `GRAMS_PER_KG` with `start`/`done`, 12-bit quotient and 10-bit remainder;
  - the controller owns the FSM, tare, stability and flag logic.

## Test plan
- **No tare:**
  - Configuration: macro off.
  - Stimulus: sample 2345.
  - Required response: at E13, integer = 2, fraction = 345, `underload` = 0, `resultValid` one cycle.
- **Default tare:**
  - Configuration: macro on.
  - Stimulus: sample 1040.
  - Required response: integer = 1, fraction = 0.
- **Underload:**
  - Stimulus: sample 30 with the default tare of 40.
  - Required response: integer = 0, fraction = 0, `underload` = 1.
- **Tare, then measure:**
  - Stimulus: `tareReq` together with sample 500; then sample 1750.
  - Required response: `tareDone` pulse and no `resultValid` for the first sample; integer = 1, fraction = 250 for the second.
- **Overrun and reset:**
  - Stimulus: a second sample at E5.
  - Required response: `overrun` = 1 and the result reflects only the first sample.
  - Stimulus: `rstN` low at E8 of a new conversion.
  - Required response: no `resultValid` and all outputs 0.
- **Stability:**
  - Stimulus: results 1000, 1003, 998, 1001, 1002 with `STABLE_COUNT` = 4.
  - Required response: `stable` rises after the 5th result.
  - Stimulus: next sample 1100.
  - Required response: `stable` drops.
